// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit handling load-use stalls, multi-cycle MDU stalls and branch flushes.
module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, BUSY, DONE} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 2);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [5:0] id_op, ex_op, ex_funct;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_load, id_uses_rt, load_use, is_mult, is_div, mdu_op;
    logic       unused_ok;

    assign id_op      = id_instr[31:26];
    assign id_rs      = id_instr[25:21];
    assign id_rt      = id_instr[20:16];
    assign ex_op      = ex_instr[31:26];
    assign ex_rt      = ex_instr[20:16];
    assign ex_funct   = ex_instr[5:0];
    assign unused_ok  = &{1'b0, id_instr[15:0], ex_instr[25:21], ex_instr[15:6]};

    assign ex_load    = (ex_op == 6'h23) && (ex_rt != 5'd0);
    assign id_uses_rt = (id_op == 6'h00) || (id_op == 6'h04) || (id_op == 6'h05) || (id_op == 6'h2B);
    assign load_use   = ex_load && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign is_mult    = (ex_op == 6'h00) && ((ex_funct == 6'h18) || (ex_funct == 6'h19));
    assign is_div     = (ex_op == 6'h00) && ((ex_funct == 6'h1A) || (ex_funct == 6'h1B));
    assign mdu_op     = is_mult || is_div;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (rst_n) begin
            case (state_q)
                BUSY: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    state_d      = (cnt_q == 4'd0) ? DONE : BUSY;
                    cnt_d        = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                end
                default: begin
                    // DONE never re-detects the MDU op still sitting in EX
                    state_d = RUN;
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (state_q == RUN && mdu_op) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        cnt_d        = is_mult ? MULT_CNT : DIV_CNT;
                        state_d      = BUSY;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
        stall_cnt_d = (!pc_write && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (ifid_flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr, ex_instr;
    logic        branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble;
    logic [15:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: remaining MDU stall cycles and whether the last stall just ended
    int busy_left = 0;
    bit done = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_instr(ex_instr),
        .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_flush(idex_flush),
        .exmem_bubble(exmem_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdu_lat(input logic [31:0] ex);
        if (ex[31:26] != 6'h00) return 0;
        if (ex[5:0] == 6'h18 || ex[5:0] == 6'h19) return MULT_LAT;
        if (ex[5:0] == 6'h1A || ex[5:0] == 6'h1B) return DIV_LAT;
        return 0;
    endfunction

    function automatic bit load_use(input logic [31:0] id, input logic [31:0] ex);
        bit uses_rt;
        uses_rt = id[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
        return ex[31:26] == 6'h23 && ex[20:16] != 0 &&
               (ex[20:16] == id[25:21] || (uses_rt && ex[20:16] == id[20:16]));
    endfunction

    task automatic step(input logic r, input logic [31:0] id, input logic [31:0] ex, input logic br);
        logic e_pc, e_ifw, e_idw, e_iff, e_idf, e_bub;
        int nb;
        bit nd;
        rst_n = r; id_instr = id; ex_instr = ex; branch_taken = br;
        #1;
        e_pc = 1; e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0; e_bub = 0;
        nb = 0; nd = 0;
        if (r) begin
            if (busy_left > 0) begin
                e_pc = 0; e_ifw = 0; e_idw = 0; e_bub = 1;
                nb = busy_left - 1;
                nd = (busy_left == 1);
            end else if (br) begin
                e_iff = 1; e_idf = 1;
            end else if (!done && mdu_lat(ex) != 0) begin
                e_pc = 0; e_ifw = 0; e_idw = 0; e_bub = 1;
                nb = mdu_lat(ex) - 1;
            end else if (load_use(id, ex)) begin
                e_pc = 0; e_ifw = 0; e_idf = 1;
            end
        end
        check("pc_write", 32'(pc_write), 32'(e_pc));
        check("ifid_write", 32'(ifid_write), 32'(e_ifw));
        check("idex_write", 32'(idex_write), 32'(e_idw));
        check("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        check("idex_flush", 32'(idex_flush), 32'(e_idf));
        check("exmem_bubble", 32'(exmem_bubble), 32'(e_bub));
        check("stall_cnt", 32'(stall_cnt), m_stall);
        check("flush_cnt", 32'(flush_cnt), m_flush);
        @(posedge clk);
        if (!r) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc) m_stall = (m_stall < 16'hFFFF) ? m_stall + 1 : m_stall;
            if (e_iff) m_flush = (m_flush < 16'hFFFF) ? m_flush + 1 : m_flush;
        end
        busy_left = nb;
        done = nd;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        ops = '{6'h23, 6'h00, 6'h04, 6'h05, 6'h2B, 6'h08};
        fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20};
        op = ops[$urandom_range(0, 5)];
        fn = fns[$urandom_range(0, 4)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) return 32'h0;
        return {op, rs, rt, 5'($urandom_range(0, 31)), 5'd0, fn};
    endfunction

    localparam logic [31:0] LW5   = {6'h23, 5'd1, 5'd5, 16'h0};
    localparam logic [31:0] LW0   = {6'h23, 5'd1, 5'd0, 16'h0};
    localparam logic [31:0] ADD6  = {6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20};
    localparam logic [31:0] ADD0  = {6'h00, 5'd0, 5'd2, 5'd6, 5'd0, 6'h20};
    localparam logic [31:0] MULT  = {6'h00, 5'd3, 5'd4, 10'd0, 6'h18};
    localparam logic [31:0] DIV   = {6'h00, 5'd3, 5'd4, 10'd0, 6'h1A};

    initial begin
        rst_n = 0; id_instr = 0; ex_instr = 0; branch_taken = 0;
        @(posedge clk); #1;
        step(0, ADD6, LW5, 1);
        step(0, 0, DIV, 0);
        step(1, ADD6, LW5, 0);
        step(1, ADD6, 0, 0);
        step(1, ADD0, LW0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, MULT, 0);
        for (int i = 0; i < 11; i++) step(1, 0, DIV, (i == 2 || i == 5) ? 1'b1 : 1'b0);
        step(1, ADD6, LW5, 1);
        step(1, ADD6, MULT, 1);
        for (int i = 0; i < 65540; i++) step(1, ADD6, LW5, 0);
        check("stall_sat", 32'(stall_cnt), 32'hFFFF);
        step(1, 0, DIV, 0);
        step(0, 0, DIV, 0);
        step(1, 0, 0, 0);
        check("reset_abort_stall", 32'(stall_cnt), 32'h0);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 63) != 0, rand_instr(), rand_instr(), $urandom_range(0, 5) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, total stall cycles for mult/multu in EX (legal 2..16).
REQ-002 SHALL have parameter DIV_LAT, default 8, total stall cycles for div/divu in EX (legal 2..16).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port id_instr  in  32  instruction held in IF/ID.
REQ-006 SHALL have port ex_instr  in  32  instruction held in ID/EX, from the ID/EX instr_out.
REQ-007 SHALL have port branch_taken  in  1  branch/jump in EX resolved taken this cycle.
REQ-008 SHALL have port pc_write  out  1  PC update enable.
REQ-009 SHALL have port ifid_write  out  1  IF/ID load enable.
REQ-010 SHALL have port ifid_flush  out  1  IF/ID load all-zero (nop).
REQ-011 SHALL have port idex_write  out  1  ID/EX load enable.
REQ-012 SHALL have port idex_flush  out  1  ID/EX load all-zero bubble.
REQ-013 SHALL have port exmem_bubble  out  1  EX/MEM captures bubble.
REQ-014 SHALL have port stall_cnt  out  16  saturating count of stall cycles.
REQ-015 SHALL have port flush_cnt  out  16  saturating count of branch flushes.

Function
REQ-016 SHALL decode fields: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
REQ-017 SHALL define EX-load as ex op==6'h23 and ex rt!=0.
REQ-018 SHALL define ID-uses-rt as id op in {6'h00, 6'h04, 6'h05, 6'h2B}.
REQ-019 SHALL define load-use as EX-load and (ex rt==id rs, or ID-uses-rt and ex rt==id rt).
REQ-020 SHALL define MDU-op as ex op==0 and funct in {18,19} (mult, latency MULT_LAT) or {1A,1B} (div, latency DIV_LAT).
REQ-021 SHALL implement FSM states RUN, BUSY, DONE; counter cnt[3:0].
REQ-022 SHALL compute all outputs combinationally from current state and inputs; the default is pc_write=ifid_write=idex_write=1 and all flush/bubble outputs 0.
REQ-023 In RUN or DONE with branch_taken=1, SHALL assert ifid_flush=1 and idex_flush=1, increment flush_cnt, and give this top priority.
REQ-024 In RUN with MDU-op and no branch_taken, SHALL drive pc_write=ifid_write=idex_write=0 and exmem_bubble=1, set cnt=latency-2, and go to BUSY.
REQ-025 In BUSY, SHALL drive the same stall outputs as REQ-024; if cnt==0 go to DONE, else decrement cnt; SHALL ignore branch_taken.
REQ-026 In DONE, SHALL apply no MDU stall; ID/EX advances; next state is always RUN (this suppresses re-detection of the same MDU op).
REQ-027 In RUN or DONE with load-use and no branch_taken, SHALL assert pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle; the bubble removes the hazard next cycle.
REQ-028 MDU priority over load-use in RUN SHALL be implied, because EX holds one instruction.
REQ-029 SHALL increment stall_cnt by 1 in each cycle where pc_write==0, saturating at 16'hFFFF.
REQ-030 SHALL saturate flush_cnt at 16'hFFFF; it never wraps.
REQ-031 A 32'h0 instruction SHALL never trigger any hazard, since rt==0 and funct==0.

Reset
REQ-032 When rst_n==0 at posedge clk, SHALL set state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
REQ-033 While rst_n==0, outputs SHALL equal the RUN defaults; counters SHALL not increment.
REQ-034 rst_n asserted mid-BUSY SHALL abort the stall; the first cycle after release is RUN.

Verification
REQ-035 ex_instr=lw $5,0($1), id_instr=add $6,$5,$2 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; then ex_instr=0 gives no stall; stall_cnt=1.
REQ-036 ex_instr=lw $0,... with id rs=0 -> no stall.
REQ-037 ex_instr=mult $3,$4, MULT_LAT=4 -> stall outputs for exactly 4 cycles, then one DONE cycle with idex_write=1, then RUN; stall_cnt=4.
REQ-038 div with DIV_LAT=8 and branch_taken pulsed during BUSY -> 8 stall cycles, no flush, flush_cnt unchanged.
REQ-039 branch_taken=1 together with a load-use condition -> ifid_flush=idex_flush=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-040 Preload stall_cnt near saturation via 65540 load-use cycles -> stall_cnt holds 16'hFFFF; rst_n=0 in cycle 2 of a div stall -> state RUN, counters 0 next cycle.
